// File: rtl/nios_sys_pio_out_blink_if.sv
// Avalon-MM slave bus bundle for the blinking output PIO.
// The master drives address/strobes/write data; the slave returns readdata
// combinationally (zero read latency, no wait states).
interface nios_sys_pio_out_blink_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/nios_sys_pio_out_blink.sv
// N-bit Avalon-MM output PIO with atomic SET/CLEAR/TOGGLE registers and
// per-bit hardware blink. A shared prescaler flips a blink phase every
// PERIOD+1 clocks; bits whose MODE bit is set follow that phase (gated by
// DATA), the rest drive DATA statically. out_port is fully registered.
module nios_sys_pio_out_blink #(
  parameter int unsigned                 DATA_WIDTH   = 8,
  parameter logic [DATA_WIDTH-1:0]       RESET_VALUE  = '0,
  parameter int unsigned                 PERIOD_WIDTH = 24,
  parameter logic [PERIOD_WIDTH-1:0]     RESET_PERIOD = PERIOD_WIDTH'(12499999)
) (
  input  logic                    clk,
  input  logic                    reset,
  nios_sys_pio_out_blink_if.slave bus,
  output logic [DATA_WIDTH-1:0]   out_port
);

  typedef enum logic [2:0] {
    ADDR_DATA   = 3'd0,
    ADDR_MODE   = 3'd1,
    ADDR_PERIOD = 3'd2,
    ADDR_STATUS = 3'd3,
    ADDR_SET    = 3'd4,
    ADDR_CLEAR  = 3'd5,
    ADDR_TOGGLE = 3'd6,
    ADDR_RSVD   = 3'd7
  } addr_e;

  logic [DATA_WIDTH-1:0]   data_q,   data_d;
  logic [DATA_WIDTH-1:0]   mode_q,   mode_d;
  logic [PERIOD_WIDTH-1:0] period_q, period_d;
  logic [PERIOD_WIDTH-1:0] cnt_q,    cnt_d;
  logic                    ph_q,     ph_d;
  logic [DATA_WIDTH-1:0]   out_q,    out_d;

  addr_e                   addr;
  logic                    wr_en;
  logic                    period_wr;
  logic [DATA_WIDTH-1:0]   wd_data;
  logic [PERIOD_WIDTH-1:0] wd_period;
  logic [31:0]             rdata;
  logic                    wd_unused;

  assign addr      = addr_e'(bus.address);
  assign wr_en     = bus.chipselect & ~bus.write_n;
  assign period_wr = wr_en && (addr == ADDR_PERIOD);
  assign wd_data   = bus.writedata[DATA_WIDTH-1:0];
  assign wd_period = bus.writedata[PERIOD_WIDTH-1:0];
  // Write data bits above the field widths are deliberately ignored.
  assign wd_unused = ^bus.writedata;

  // Register writes, including the single-cycle read-modify-write aliases.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    data_d   = data_q;
    mode_d   = mode_q;
    period_d = period_q;
    if (wr_en) begin
      unique case (addr)
        ADDR_DATA:   data_d   = wd_data;
        ADDR_MODE:   mode_d   = wd_data;
        ADDR_PERIOD: period_d = wd_period;
        ADDR_SET:    data_d   = data_q | wd_data;
        ADDR_CLEAR:  data_d   = data_q & ~wd_data;
        ADDR_TOGGLE: data_d   = data_q ^ wd_data;
        default:     ; // STATUS is read-only, 7 is reserved
      endcase
    end
  end

  // Prescaler: a PERIOD write restarts the blink cleanly and beats a
  // coincident wrap, so a new period below the running count is harmless.
  always_comb begin
    cnt_d = cnt_q + PERIOD_WIDTH'(1);
    ph_d  = ph_q;
    if (period_wr) begin
      cnt_d = '0;
      ph_d  = 1'b0;
    end else if (cnt_q == period_q) begin
      cnt_d = '0;
      ph_d  = ~ph_q;
    end
  end

  // Static bits pass DATA; blink bits pass DATA only during the high phase.
  assign out_d = (data_q & ~mode_q) | (data_q & mode_q & {DATA_WIDTH{ph_q}});

  // State registers with synchronous reset; reset beats any coincident write.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      // NOTE: every register, including the output, is reset so out_port
      // shows RESET_VALUE on the reset edge rather than a cycle later.
      data_q   <= RESET_VALUE;
      mode_q   <= '0;
      period_q <= RESET_PERIOD;
      cnt_q    <= '0;
      ph_q     <= 1'b0;
      out_q    <= RESET_VALUE;
    end else begin
      data_q   <= data_d;
      mode_q   <= mode_d;
      period_q <= period_d;
      cnt_q    <= cnt_d;
      ph_q     <= ph_d;
      out_q    <= out_d;
    end
  end

  // Zero-latency read mux; unselected, write-only and reserved reads give 0.
  always_comb begin
    rdata = '0;
    if (bus.chipselect) begin
      unique case (addr)
        ADDR_DATA:   rdata[DATA_WIDTH-1:0]   = data_q;
        ADDR_MODE:   rdata[DATA_WIDTH-1:0]   = mode_q;
        ADDR_PERIOD: rdata[PERIOD_WIDTH-1:0] = period_q;
        ADDR_STATUS: rdata[DATA_WIDTH-1:0]   = out_q;
        default:     rdata                   = '0;
      endcase
    end
  end

  assign bus.readdata = rdata;
  assign out_port     = out_q;

endmodule

// File: tb/tb_nios_sys_pio_out_blink.sv
// Bench for nios_sys_pio_out_blink: an 8-bit instance tracked cycle by cycle
// by a behavioural model (expected out_port pushed per driven cycle, popped
// after the edge), plus a 1-bit / 4-bit-prescaler instance for width limits.
module tb_nios_sys_pio_out_blink;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  nios_sys_pio_out_blink_if bus8 ();
  nios_sys_pio_out_blink_if bus1 ();
  logic [7:0] out8;
  logic [0:0] out1;

  nios_sys_pio_out_blink #(
    .DATA_WIDTH  (8),
    .RESET_VALUE (8'hA5),
    .PERIOD_WIDTH(24),
    .RESET_PERIOD(24'd12499999)
  ) dut8 (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus8.slave),
    .out_port(out8)
  );

  nios_sys_pio_out_blink #(
    .DATA_WIDTH  (1),
    .RESET_VALUE (1'b0),
    .PERIOD_WIDTH(4),
    .RESET_PERIOD(4'd9)
  ) dut1 (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus1.slave),
    .out_port(out1)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model of the 8-bit instance and its out_port scoreboard.
  logic [7:0]  m_data, m_mode, m_out;
  logic [23:0] m_period, m_cnt;
  logic        m_ph;
  logic [7:0]  exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    logic       wr;
    logic [7:0] wd;
    logic [7:0] nxt_out;
    wr = bus8.chipselect && !bus8.write_n;
    wd = bus8.writedata[7:0];
    if (reset) begin
      m_data = 8'hA5; m_mode = 8'h00; m_period = 24'd12499999;
      m_cnt  = 24'd0; m_ph = 1'b0;    m_out = 8'hA5;
    end else begin
      nxt_out = 8'h00;
      for (int b = 0; b < 8; b++)
        nxt_out[b] = m_data[b] && (!m_mode[b] || m_ph);
      if (wr && bus8.address == 3'd2) begin
        m_period = bus8.writedata[23:0];
        m_cnt = 24'd0;
        m_ph  = 1'b0;
      end else if (m_cnt == m_period) begin
        m_cnt = 24'd0;
        m_ph  = !m_ph;
      end else begin
        m_cnt = m_cnt + 24'd1;
      end
      if (wr) begin
        case (bus8.address)
          3'd0: m_data = wd;
          3'd1: m_mode = wd;
          3'd4: m_data = m_data | wd;
          3'd5: m_data = m_data & ~wd;
          3'd6: m_data = m_data ^ wd;
          default: ;
        endcase
      end
      m_out = nxt_out;
    end
  endtask

  // One clock: predict, let the edge happen, compare out_port after it.
  task automatic tick();
    model_step();
    exp_q.push_back(m_out);
    @(posedge clk);
    #1;
    check("out_port", out8, exp_q.pop_front());
  endtask

  task automatic wr8(input logic [2:0] a, input logic [31:0] d);
    bus8.chipselect = 1'b1;
    bus8.write_n    = 1'b0;
    bus8.address    = a;
    bus8.writedata  = d;
    tick();
    bus8.chipselect = 1'b0;
    bus8.write_n    = 1'b1;
    bus8.writedata  = 32'h0;
  endtask

  task automatic rd8(input string tag, input logic [2:0] a, input logic [31:0] exp);
    bus8.chipselect = 1'b1;
    bus8.write_n    = 1'b1;
    bus8.address    = a;
    #1;
    check(tag, bus8.readdata, exp);
    bus8.chipselect = 1'b0;
  endtask

  task automatic wr1(input logic [2:0] a, input logic [31:0] d);
    bus1.chipselect = 1'b1;
    bus1.write_n    = 1'b0;
    bus1.address    = a;
    bus1.writedata  = d;
    tick();
    bus1.chipselect = 1'b0;
    bus1.write_n    = 1'b1;
    bus1.writedata  = 32'h0;
  endtask

  task automatic rd1(input string tag, input logic [2:0] a, input logic [31:0] exp);
    bus1.chipselect = 1'b1;
    bus1.write_n    = 1'b1;
    bus1.address    = a;
    #1;
    check(tag, bus1.readdata, exp);
    bus1.chipselect = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    bus8.chipselect = 1'b0; bus8.write_n = 1'b1; bus8.address = 3'd0; bus8.writedata = 32'h0;
    bus1.chipselect = 1'b0; bus1.write_n = 1'b1; bus1.address = 3'd0; bus1.writedata = 32'h0;

    // 1. Reset state and DATA write latency.
    tick();
    tick();
    check("rst_out", out8, 32'hA5);
    reset = 1'b0;
    rd8("rst_mode", 3'd1, 32'h0);
    rd8("rst_period", 3'd2, 32'd12499999);
    rd8("rst_data", 3'd0, 32'hA5);
    rd8("rst_status", 3'd3, 32'hA5);
    bus8.address = 3'd0;
    #1;
    check("cs0_read", bus8.readdata, 32'h0);
    wr8(3'd0, 32'h3C);
    check("data_lat_edge", out8, 32'hA5);
    tick();
    check("data_lat_next", out8, 32'h3C);
    rd8("status_3c", 3'd3, 32'h3C);

    // 2. Atomic aliases, ignored upper bits, read-only / reserved addresses.
    wr8(3'd4, 32'h81);
    rd8("set", 3'd0, 32'hBD);
    wr8(3'd5, 32'h0F);
    rd8("clear", 3'd0, 32'hB0);
    wr8(3'd6, 32'hFF);
    rd8("toggle", 3'd0, 32'h4F);
    wr8(3'd4, 32'hFFFF_FF00);
    rd8("set_upper", 3'd0, 32'h4F);
    wr8(3'd0, 32'hFFFF_FF4F);
    rd8("data_upper", 3'd0, 32'h4F);
    wr8(3'd3, 32'h0);
    wr8(3'd7, 32'hFF);
    rd8("ro_rsvd_wr", 3'd0, 32'h4F);
    for (int a = 4; a < 8; a++)
      rd8($sformatf("rd_addr%0d", a), 3'(a), 32'h0);
    tick();
    check("status_4f", out8, 32'h4F);

    // 3. Blink with PERIOD=3, then PERIOD=0.
    wr8(3'd1, 32'h01);
    wr8(3'd0, 32'h03);
    wr8(3'd2, 32'h03);
    for (int k = 1; k <= 16; k++) begin
      tick();
      check("blink_b1", 32'(out8[1]), 32'h1);
      check($sformatf("blink3_b0_k%0d", k), 32'(out8[0]), 32'((k - 1) / 4 % 2));
    end
    wr8(3'd2, 32'h0);
    for (int k = 1; k <= 6; k++) begin
      tick();
      check($sformatf("blink0_b0_k%0d", k), 32'(out8[0]), 32'((k - 1) % 2));
    end

    // 4. PERIOD write on the exact wrap cycle wins over the toggle.
    wr8(3'd2, 32'h3);
    for (int k = 0; k < 3; k++) tick();
    check("cnt_at_wrap", 32'(m_cnt), 32'd3);
    wr8(3'd2, 32'h5);
    for (int k = 1; k <= 7; k++) begin
      tick();
      check($sformatf("wrap_prio_b0_k%0d", k), 32'(out8[0]), (k == 7) ? 32'h1 : 32'h0);
    end

    // 5. Reset mid-blink with a coincident DATA write.
    bus8.chipselect = 1'b1; bus8.write_n = 1'b0; bus8.address = 3'd0; bus8.writedata = 32'h77;
    reset = 1'b1;
    tick();
    check("rst_wr_out", out8, 32'hA5);
    reset = 1'b0;
    bus8.chipselect = 1'b0; bus8.write_n = 1'b1; bus8.writedata = 32'h0;
    rd8("rst_wr_data", 3'd0, 32'hA5);
    rd8("rst_wr_mode", 3'd1, 32'h0);
    rd8("rst_wr_period", 3'd2, 32'd12499999);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("rst_static", out8, 32'hA5);
    end

    // 6. One-bit port with a 4-bit prescaler.
    rd1("w1_rst_period", 3'd2, 32'h9);
    wr1(3'd0, 32'hFFFF_FFFF);
    wr1(3'd1, 32'h1);
    wr1(3'd2, 32'hFFFF_FFFF);
    rd1("w1_period", 3'd2, 32'hF);
    rd1("w1_data", 3'd0, 32'h1);
    for (int k = 1; k <= 34; k++) begin
      tick();
      check($sformatf("w1_blink_k%0d", k), 32'(out1), 32'((k - 1) / 16 % 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
